// File: rtl/vga_timing_pkg.sv
//------------------------------------------------------------------------------
// Module  : vga_timing_pkg
// Brief   : 640x480@60 default raster constants, shared types and clog2 helper.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

    localparam int c_H_ACTIVE   = 640;
    localparam int c_H_FP       = 16;
    localparam int c_H_SYNC     = 96;
    localparam int c_H_BP       = 48;
    localparam int c_H_TOTAL    = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;

    localparam int c_V_ACTIVE   = 480;
    localparam int c_V_FP       = 10;
    localparam int c_V_SYNC     = 2;
    localparam int c_V_BP       = 33;
    localparam int c_V_TOTAL    = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;

    localparam logic c_SYNC_POL   = 1'b0;
    localparam int   c_FETCH_LEAD = 2;
    localparam int   c_COLOR_W    = 8;
    localparam int   c_REQ_X_W    = 10;
    localparam int   c_REQ_Y_W    = 9;

    // Timing bits carried alongside the pixel fetch latency.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
        logic fs;
    } timing_bits_t;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_generator_if.sv
//------------------------------------------------------------------------------
// Module  : vga_timing_generator_if
// Brief   : Pixel-fetch request/return bus plus VGA DAC output bundle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vga_timing_generator_if
    import vga_timing_pkg::*;
#(
    parameter int COLOR_W = c_COLOR_W
);

    logic                 pixel_req;
    logic [c_REQ_X_W-1:0] req_x;
    logic [c_REQ_Y_W-1:0] req_y;
    logic [COLOR_W-1:0]   pixel_r;
    logic [COLOR_W-1:0]   pixel_g;
    logic [COLOR_W-1:0]   pixel_b;
    logic [COLOR_W-1:0]   vga_r;
    logic [COLOR_W-1:0]   vga_g;
    logic [COLOR_W-1:0]   vga_b;
    logic                 vga_hs;
    logic                 vga_vs;
    logic                 vga_blank_n;
    logic                 vga_sync_n;
    logic                 frame_start;

    modport master (
        output pixel_req, req_x, req_y,
        input  pixel_r, pixel_g, pixel_b,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start
    );

    modport slave (
        input  pixel_req, req_x, req_y,
        output pixel_r, pixel_g, pixel_b,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start
    );

endinterface

`default_nettype wire

// File: rtl/vga_delay_line.sv
//------------------------------------------------------------------------------
// Module  : vga_delay_line
// Brief   : WIDTH x DEPTH shift register with async clear to a supplied value.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clock_in,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] reset_value,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clock_in or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= reset_value;
            end
        end else begin
            r_stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign dout = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_timing_generator.sv
//------------------------------------------------------------------------------
// Module  : vga_timing_generator
// Brief   : Raster counters, lead-time pixel fetch requests and aligned VGA outputs.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE   = c_H_ACTIVE,
    parameter int   H_FP       = c_H_FP,
    parameter int   H_SYNC     = c_H_SYNC,
    parameter int   H_BP       = c_H_BP,
    parameter int   V_ACTIVE   = c_V_ACTIVE,
    parameter int   V_FP       = c_V_FP,
    parameter int   V_SYNC     = c_V_SYNC,
    parameter int   V_BP       = c_V_BP,
    parameter logic SYNC_POL   = c_SYNC_POL,
    parameter int   FETCH_LEAD = c_FETCH_LEAD
) (
    input  logic                          clock_in,
    input  logic                          aresetn,
    input  logic                          enable,
    vga_timing_generator_if.master        bus
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = clog2(c_H_TOTAL);
    localparam int c_VW      = clog2(c_V_TOTAL);

    localparam logic [c_HW-1:0] c_H_LAST     = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT      = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_HS_START   = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_END     = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST     = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT      = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_VS_START   = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_END     = c_VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam timing_bits_t    c_IDLE_BITS  = '{hs: ~SYNC_POL, vs: ~SYNC_POL, blank_n: 1'b0, fs: 1'b0};

    logic [c_HW-1:0] r_h_cnt;
    logic [c_VW-1:0] r_v_cnt;
    logic            w_active;
    timing_bits_t    w_raw;
    timing_bits_t    w_dly;

    always_ff @(posedge clock_in or negedge aresetn) begin
        if (!aresetn) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!enable) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Raw timing is forced idle while disabled so the pipeline drains to blank.
    always_comb begin
        w_raw         = c_IDLE_BITS;
        w_active      = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
        w_raw.blank_n = w_active && enable;
        w_raw.fs      = enable && (r_h_cnt == '0) && (r_v_cnt == '0);
        if (enable && (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END)) begin
            w_raw.hs = SYNC_POL;
        end
        if (enable && (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END)) begin
            w_raw.vs = SYNC_POL;
        end
    end

    // Request is masked by reset directly so it drops the moment reset asserts.
    assign bus.pixel_req = w_raw.blank_n && aresetn;
    assign bus.req_x     = bus.pixel_req ? c_REQ_X_W'(r_h_cnt) : '0;
    assign bus.req_y     = bus.pixel_req ? c_REQ_Y_W'(r_v_cnt) : '0;
    assign bus.vga_sync_n = 1'b0;

    vga_delay_line #(
        .WIDTH ($bits(timing_bits_t)),
        .DEPTH (FETCH_LEAD)
    ) u_delay (
        .clock_in    (clock_in),
        .aresetn     (aresetn),
        .reset_value (c_IDLE_BITS),
        .din         (w_raw),
        .dout        (w_dly)
    );

    always_ff @(posedge clock_in or negedge aresetn) begin
        if (!aresetn) begin
            bus.vga_r       <= '0;
            bus.vga_g       <= '0;
            bus.vga_b       <= '0;
            bus.vga_hs      <= ~SYNC_POL;
            bus.vga_vs      <= ~SYNC_POL;
            bus.vga_blank_n <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.vga_r       <= w_dly.blank_n ? bus.pixel_r : '0;
            bus.vga_g       <= w_dly.blank_n ? bus.pixel_g : '0;
            bus.vga_b       <= w_dly.blank_n ? bus.pixel_b : '0;
            bus.vga_hs      <= w_dly.hs;
            bus.vga_vs      <= w_dly.vs;
            bus.vga_blank_n <= w_dly.blank_n;
            bus.frame_start <= w_dly.fs;
        end
    end

endmodule

`default_nettype wire
